mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Clocked bus master between the CPU control unit and the asynchronous byte-addressed 512x8 data RAM. Accepts one load/store request at a time, validates opcode, alignment and range, drives the RAM's MOV/ReadWrite/OP/Address/DataIn lines, and waits for MOC with a timeout. It then returns load data, sign-extended for lb/lh, which the RAM itself only zero-extends.

## Interface
- TIMEOUT, 15: max WAIT cycles with MOC low before aborting.
- ADDR_LIMIT, 512: memory size in bytes; last byte of an access must be < ADDR_LIMIT.

- clk  in  1  single system clock; all state on rising edge.
- reset  in  1  synchronous, active-high.
- req  in  1  request; accepted only on an edge where ready=1.
- op_in  in  6  MIPS opcode: lw 100011, lh 100001, lhu 100101, lb 100000, lbu 100100, sw 101011, sh 101001, sb 101000.
- addr_in  in  32  byte address.
- wdata_in  in  32  store data, right-justified.
- ready  out  1  idle, can accept req.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  one-cycle pulse on rejected or timed-out access.
- rdata  out  32  load result, registered.
- MOV  out  1  memory operation valid to RAM.
- ReadWrite  out  1  1=read, 0=write.
- OP  out  6  opcode presented to RAM (RAM encoding).
- Address  out  32  RAM address.
- DataIn  out  32  RAM write data.
- DataOut  in  32  RAM read data.
- MOC  in  1  memory operation complete.

## Operation
- States: IDLE, SETUP, STROBE, WAIT, DONE.
- IDLE: ready=1, MOV=0. On req: latch op/addr/wdata, run checks.
  - Illegal opcode, misaligned (word: addr[1:0]!=0; half: addr[0]!=0), or addr+size-1 >= ADDR_LIMIT → stay IDLE, error=1 next cycle. No RAM activity.
  - Otherwise → SETUP.
- SETUP: drive Address, OP, ReadWrite, DataIn; MOV=0. Gives the RAM a stable bus before MOV rises. → STROBE.
- STROBE: MOV=1. MOC is ignored in this cycle because it may be stale from the prior access. Clear the wait counter. → WAIT.
- WAIT: MOV=1.
  - MOC=1 → capture result, go to DONE.
  - Otherwise increment the counter. If the counter reaches TIMEOUT → drop MOV, error=1 next cycle, go to IDLE; rdata unchanged.
- DONE: MOV=0, done=1 for exactly one cycle. → IDLE.
- Opcode translation to OP: lh→100101, lb→100100. All other legal opcodes pass through unchanged.
- Load result into rdata:
  - lw: DataOut.
  - lh: {16{DataOut[15]}, DataOut[15:0]}.
  - lb: {24{DataOut[7]}, DataOut[7:0]}.
  - lhu/lbu: zero-extended DataOut.
- Stores leave rdata unchanged. DataIn = wdata_in unmodified; the RAM uses the low bits.
- Bus outputs (Address/OP/ReadWrite/DataIn) hold their values from SETUP through DONE and are not changed in IDLE. This prevents spurious RAM re-triggers.
- MOV always returns low between accesses, so every access presents a fresh MOV rising edge.

## Timing
- Reset values: ready=1, done=0, error=0, rdata=0, MOV=0, ReadWrite=1, OP=0, Address=0, DataIn=0, state IDLE, counter 0.
- Accept at edge E0. The access cycle sequence is:
  - SETUP after E0.
  - MOV=1 after E1.
  - First MOC sample at E3.
  - done and rdata valid after E3.
  - ready=1 after E4.
  - Minimum latency is 4 cycles from accept to done.
- Each extra WAIT cycle adds 1 cycle. A timeout produces error TIMEOUT+3 cycles after accept.
- Validation error: error high in the cycle after E0, and ready stays 1.
- req while ready=0 is ignored; no queueing.
- done and error are never high together.
- MOC requirement on the RAM: low within one clk period of MOV rising, then high, held until MOV falls.
- MOC and DataOut are sampled directly on clk. A MOC rising in the same cycle as the counter reaching TIMEOUT counts as success, because MOC has priority.
- Reset asserted mid-access: the next edge forces IDLE with MOV=0 and all outputs at reset values. No done or error pulse is produced.

## Test plan
- lw 0x00000010 with RAM bytes 12 34 56 78 and MOC after 1 WAIT cycle → done 4 cycles after accept, rdata=0x12345678, OP=100011.
- lb 0x00000005, byte 0x80 → OP=100100 on bus, rdata=0xFFFFFF80. Then lbu at the same address → rdata=0x00000080.
- sh 0x00000020, wdata=0xAAAA1234 → ReadWrite=0, OP=101001, DataIn=0xAAAA1234, done pulse, rdata unchanged. A following lhu at 0x20 → 0x00001234.
- lw 0x00000002 (misaligned), lw 0x000001FE (range), and op 001000 → error 1 cycle after accept each time, MOV never rises, ready stays 1.
- MOC held low → MOV high for TIMEOUT+1 cycles, then error pulse, MOV=0, ready=1. A subsequent good lw completes normally.
- Assert reset in WAIT → MOV=0 and all outputs at reset values the next cycle, no done or error pulse; a req after reset completes normally.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Bus master between the CPU control unit and the asynchronous 512x8 data RAM.
// Takes one load/store at a time and checks its opcode, alignment and range.
// It then runs a SETUP / STROBE / WAIT handshake against MOC, with a timeout.
// Sign extension for lb/lh is applied on the way back, because the RAM only
// zero-extends.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | ready=1, MOV=0, bus held; validates and accepts a request
// SETUP  | bus lines freshly driven, MOV still low so the RAM sees a stable bus
// STROBE | MOV=1; MOC ignored (may be stale from the previous access)
// WAIT   | MOV=1; MOC captures the result, else count toward timeout
// DONE   | MOV=0, one-cycle done pulse

module mem_access_ctrl #(
    parameter int TIMEOUT    = 15,
    parameter int ADDR_LIMIT = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [5:0]  op_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    output logic        ready,
    output logic        done,
    output logic        error,
    output logic [31:0] rdata,
    output logic        MOV,
    output logic        ReadWrite,
    output logic [5:0]  OP,
    output logic [31:0] Address,
    output logic [31:0] DataIn,
    input  logic [31:0] DataOut,
    input  logic        MOC
);

    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_STROBE = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SB  = 6'b101000;

    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [5:0]    r_op_req;
    logic          r_error;
    logic [31:0]   r_rdata;
    logic          r_rw;
    logic [5:0]    r_op;
    logic [31:0]   r_addr;
    logic [31:0]   r_din;

    logic          w_legal;
    logic          w_is_load;
    logic [2:0]    w_size;
    logic [5:0]    w_ram_op;
    logic          w_misaligned;
    logic [32:0]   w_last;
    logic          w_out_of_range;
    logic          w_reject;
    logic [CW-1:0] w_cnt_next;
    logic [31:0]   w_load_data;

    // Decode the incoming opcode: legality, access size, direction, RAM opcode.
    always_comb begin
        w_legal   = 1'b1;
        w_is_load = 1'b1;
        w_size    = 3'd0;
        w_ram_op  = op_in;
        case (op_in)
            OP_LW:   w_size = 3'd4;
            OP_LH:   begin w_size = 3'd2; w_ram_op = OP_LHU; end
            OP_LHU:  w_size = 3'd2;
            OP_LB:   begin w_size = 3'd1; w_ram_op = OP_LBU; end
            OP_LBU:  w_size = 3'd1;
            OP_SW:   begin w_size = 3'd4; w_is_load = 1'b0; end
            OP_SH:   begin w_size = 3'd2; w_is_load = 1'b0; end
            OP_SB:   begin w_size = 3'd1; w_is_load = 1'b0; end
            default: w_legal = 1'b0;
        endcase
    end

    // Use a 33-bit sum so that addresses near 2^32 cannot wrap into range.
    assign w_misaligned   = ((w_size == 3'd4) && (addr_in[1:0] != 2'b00)) ||
                            ((w_size == 3'd2) && addr_in[0]);
    assign w_last         = {1'b0, addr_in} + {30'd0, w_size} - 33'd1;
    assign w_out_of_range = (w_last >= 33'(ADDR_LIMIT));
    assign w_reject       = !w_legal || w_misaligned || w_out_of_range;
    assign w_cnt_next     = r_cnt + 1'b1;

    // Sign- or zero-extend the RAM word according to the original opcode.
    always_comb begin
        w_load_data = DataOut;
        case (r_op_req)
            OP_LH:   w_load_data = {{16{DataOut[15]}}, DataOut[15:0]};
            OP_LHU:  w_load_data = {16'h0000, DataOut[15:0]};
            OP_LB:   w_load_data = {{24{DataOut[7]}}, DataOut[7:0]};
            OP_LBU:  w_load_data = {24'h000000, DataOut[7:0]};
            default: w_load_data = DataOut;
        endcase
    end

    // Access sequencing, the wait/timeout counter and the error pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_error  <= 1'b0;
            r_op_req <= 6'd0;
        end else begin
            r_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        if (w_reject) begin
                            r_error <= 1'b1;
                        end else begin
                            r_op_req <= op_in;
                            r_state  <= S_SETUP;
                        end
                    end
                end
                S_SETUP:  r_state <= S_STROBE;
                S_STROBE: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (MOC) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= w_cnt_next;
                        if (w_cnt_next == CW'(TIMEOUT)) begin
                            r_error <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_DONE:   r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    // Bus lines change only when a request is accepted, then hold through DONE and IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rw   <= 1'b1;
            r_op   <= 6'd0;
            r_addr <= 32'd0;
            r_din  <= 32'd0;
        end else if ((r_state == S_IDLE) && req && !w_reject) begin
            r_rw   <= w_is_load;
            r_op   <= w_ram_op;
            r_addr <= addr_in;
            r_din  <= wdata_in;
        end
    end

    // Load result is captured on the completing MOC sample. Stores leave rdata alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= 32'd0;
        end else if ((r_state == S_WAIT) && MOC && r_rw) begin
            r_rdata <= w_load_data;
        end
    end

    assign ready     = (r_state == S_IDLE);
    assign done      = (r_state == S_DONE);
    assign MOV       = (r_state == S_STROBE) || (r_state == S_WAIT);
    assign error     = r_error;
    assign rdata     = r_rdata;
    assign ReadWrite = r_rw;
    assign OP        = r_op;
    assign Address   = r_addr;
    assign DataIn    = r_din;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: behavioural byte RAM with programmable MOC delay
// plus a transaction-level reference model of outcome, latency and load results.

module tb_mem_access_ctrl;

    localparam int TIMEOUT    = 15;
    localparam int ADDR_LIMIT = 512;

    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] LH  = 6'b100001;
    localparam logic [5:0] LHU = 6'b100101;
    localparam logic [5:0] LB  = 6'b100000;
    localparam logic [5:0] LBU = 6'b100100;
    localparam logic [5:0] SW  = 6'b101011;
    localparam logic [5:0] SH  = 6'b101001;
    localparam logic [5:0] SB  = 6'b101000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic [5:0]  op_in = 6'd0;
    logic [31:0] addr_in = 32'd0;
    logic [31:0] wdata_in = 32'd0;
    logic        ready, done, error, MOV, ReadWrite;
    logic [31:0] rdata, Address, DataIn;
    logic [5:0]  OP;
    logic [31:0] DataOut = 32'd0;
    logic        MOC = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    mem_access_ctrl #(.TIMEOUT(TIMEOUT), .ADDR_LIMIT(ADDR_LIMIT)) dut (
        .clk(clk), .reset(reset), .req(req), .op_in(op_in), .addr_in(addr_in),
        .wdata_in(wdata_in), .ready(ready), .done(done), .error(error), .rdata(rdata),
        .MOV(MOV), .ReadWrite(ReadWrite), .OP(OP), .Address(Address), .DataIn(DataIn),
        .DataOut(DataOut), .MOC(MOC)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural RAM ----------------
    logic [7:0] ram_mem [ADDR_LIMIT];
    int ram_cnt   = 0;
    int moc_delay = 0;   // WAIT samples with MOC low before MOC rises
    bit ram_stale = 1'b0; // MOC high during STROBE (stale from a previous access)

    task automatic ram_access();
        logic [8:0] a;
        a = Address[8:0];
        case (OP)
            6'b100011: DataOut = {ram_mem[a], ram_mem[a+9'd1], ram_mem[a+9'd2], ram_mem[a+9'd3]};
            6'b100101: DataOut = {16'h0000, ram_mem[a], ram_mem[a+9'd1]};
            6'b100100: DataOut = {24'h000000, ram_mem[a]};
            6'b101011: begin
                ram_mem[a] = DataIn[31:24]; ram_mem[a+9'd1] = DataIn[23:16];
                ram_mem[a+9'd2] = DataIn[15:8]; ram_mem[a+9'd3] = DataIn[7:0];
            end
            6'b101001: begin ram_mem[a] = DataIn[15:8]; ram_mem[a+9'd1] = DataIn[7:0]; end
            6'b101000: ram_mem[a] = DataIn[7:0];
            default:   DataOut = $urandom;
        endcase
    endtask

    always @(negedge clk) begin
        if (!MOV) begin
            ram_cnt = 0;
            MOC     = 1'b0;
            DataOut = $urandom;
        end else begin
            ram_cnt++;
            if (ram_cnt == 1) MOC = ram_stale;
            else if (ram_cnt < 2 + moc_delay) MOC = 1'b0;
            else begin
                if (ram_cnt == 2 + moc_delay) ram_access();
                MOC = 1'b1;
            end
        end
    end

    // ---------------- reference model ----------------
    logic [7:0]  ref_mem [ADDR_LIMIT];
    logic [31:0] m_rdata = 32'd0;
    logic [5:0]  m_op = 6'd0;
    logic        m_rw = 1'b1;
    logic [31:0] m_addr = 32'd0;
    logic [31:0] m_din = 32'd0;
    int exp_kind, exp_cyc, exp_mov;   // kind: 1 done, 2 error

    function automatic int ref_size(input logic [5:0] op);
        if (op == LW || op == SW) return 4;
        if (op == LH || op == LHU || op == SH) return 2;
        if (op == LB || op == LBU || op == SB) return 1;
        return 0;
    endfunction

    function automatic bit ref_is_load(input logic [5:0] op);
        return (op == LW || op == LH || op == LHU || op == LB || op == LBU);
    endfunction

    function automatic logic [31:0] ref_load(input logic [5:0] op, input logic [31:0] addr);
        int unsigned b;
        logic [31:0] h, v;
        b = addr;
        if (ref_size(op) == 4) begin
            v = ref_mem[b] * 32'h1000000 + ref_mem[b+1] * 32'h10000 + ref_mem[b+2] * 32'h100 + 32'(ref_mem[b+3]);
        end else if (ref_size(op) == 2) begin
            h = ref_mem[b] * 32'h100 + 32'(ref_mem[b+1]);
            v = (op == LH && h >= 32'h8000) ? h - 32'h10000 : h;
        end else begin
            h = 32'(ref_mem[b]);
            v = (op == LB && h >= 32'h80) ? h - 32'h100 : h;
        end
        return v;
    endfunction

    task automatic ref_predict(input logic [5:0] op, input logic [31:0] addr,
                               input logic [31:0] wdata, input int delay);
        int sz;
        bit valid;
        int unsigned b;
        sz = ref_size(op);
        valid = (sz != 0) && ((addr % 32'(sz)) == 0) &&
                (({32'd0, addr} + 64'(sz) - 64'd1) < 64'(ADDR_LIMIT));
        if (!valid) begin
            exp_kind = 2; exp_cyc = 1; exp_mov = 0;
            return;
        end
        m_op   = (op == LH) ? LHU : (op == LB) ? LBU : op;
        m_rw   = ref_is_load(op);
        m_addr = addr;
        m_din  = wdata;
        if (delay >= TIMEOUT) begin
            exp_kind = 2; exp_cyc = TIMEOUT + 3; exp_mov = TIMEOUT + 1;
            return;
        end
        exp_kind = 1; exp_cyc = 4 + delay; exp_mov = delay + 2;
        b = addr;
        if (m_rw) m_rdata = ref_load(op, addr);
        else for (int i = 0; i < sz; i++) ref_mem[b + i] = 8'(wdata >> (8 * (sz - 1 - i)));
    endtask

    // ---------------- transaction driver / observer ----------------
    int obs_kind, obs_cyc, obs_mov;
    bit obs_both, obs_ready0, obs_ready_res, obs_ready_after, obs_mov_after, obs_extra;
    logic [31:0] obs_rdata, obs_addr, obs_din;
    logic [5:0]  obs_op;
    logic        obs_rw;

    task automatic run_access(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                              input int delay, input bit stale, input bit busy);
        @(negedge clk);
        moc_delay = delay; ram_stale = stale;
        obs_ready0 = ready;
        req = 1'b1; op_in = op; addr_in = addr; wdata_in = wdata;
        @(posedge clk);
        #1;
        req = busy;
        op_in    = busy ? LW : 6'($urandom);
        addr_in  = busy ? 32'h100 : $urandom;
        wdata_in = $urandom;
        obs_kind = 0; obs_cyc = 0; obs_mov = 0; obs_both = 0; obs_ready_res = 0;
        for (int c = 1; c <= 40 && obs_kind == 0; c++) begin
            @(negedge clk);
            if (MOV) obs_mov++;
            if (done && error) obs_both = 1;
            if (done || error) begin
                obs_kind = done ? 1 : 2; obs_cyc = c;
                obs_rdata = rdata; obs_op = OP; obs_rw = ReadWrite;
                obs_addr = Address; obs_din = DataIn; obs_ready_res = ready;
            end
            req = busy && !ready;
        end
        @(negedge clk);
        req = 1'b0;
        obs_ready_after = ready; obs_mov_after = MOV; obs_extra = done || error;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; req = 1'b1; op_in = LW; addr_in = 32'h10;
        repeat (3) @(negedge clk);
        req = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", ready); end
        n_cmp++; if ({done, error, MOV} !== 3'b000) begin n_bad++; $display("FAIL reset_pulses got %b want 000", {done, error, MOV}); end
        n_cmp++; if (rdata !== 32'd0) begin n_bad++; $display("FAIL reset_rdata got %h want 0", rdata); end
        n_cmp++; if ({ReadWrite, OP, Address, DataIn} !== {1'b1, 6'd0, 32'd0, 32'd0}) begin
            n_bad++; $display("FAIL reset_bus got rw=%b op=%b a=%h d=%h want rw=1 op=0 a=0 d=0", ReadWrite, OP, Address, DataIn); end
    endtask

    task automatic test_lw_basic();
        ref_predict(LW, 32'h10, 32'h0, 0);
        run_access(LW, 32'h10, 32'hDEADBEEF, 0, 0, 0);
        n_cmp++; if (obs_kind !== 1 || obs_cyc !== 4) begin n_bad++; $display("FAIL lw_latency got kind=%0d cyc=%0d want kind=1 cyc=4", obs_kind, obs_cyc); end
        n_cmp++; if (obs_rdata !== 32'h12345678) begin n_bad++; $display("FAIL lw_rdata got %h want 12345678", obs_rdata); end
        n_cmp++; if (obs_op !== LW || obs_rw !== 1'b1) begin n_bad++; $display("FAIL lw_op got op=%b rw=%b want 100011/1", obs_op, obs_rw); end
        n_cmp++; if (obs_mov !== 2 || obs_ready_after !== 1'b1) begin n_bad++; $display("FAIL lw_mov got mov=%0d rdy=%b want 2/1", obs_mov, obs_ready_after); end
    endtask

    task automatic test_sign_ext();
        ref_predict(LB, 32'h5, 32'h0, 1);
        run_access(LB, 32'h5, 32'h0, 1, 0, 0);
        n_cmp++; if (obs_kind !== 1 || obs_cyc !== 5) begin n_bad++; $display("FAIL lb_latency got kind=%0d cyc=%0d want 1/5", obs_kind, obs_cyc); end
        n_cmp++; if (obs_op !== 6'b100100) begin n_bad++; $display("FAIL lb_op got %b want 100100", obs_op); end
        n_cmp++; if (obs_rdata !== 32'hFFFFFF80) begin n_bad++; $display("FAIL lb_rdata got %h want ffffff80", obs_rdata); end
        ref_predict(LBU, 32'h5, 32'h0, 0);
        run_access(LBU, 32'h5, 32'h0, 0, 1, 0);
        n_cmp++; if (obs_rdata !== 32'h00000080) begin n_bad++; $display("FAIL lbu_rdata got %h want 00000080", obs_rdata); end
    endtask

    task automatic test_store();
        ref_predict(SH, 32'h20, 32'hAAAA1234, 0);
        run_access(SH, 32'h20, 32'hAAAA1234, 0, 1, 0);
        n_cmp++; if (obs_kind !== 1) begin n_bad++; $display("FAIL sh_done got kind=%0d want 1", obs_kind); end
        n_cmp++; if ({obs_rw, obs_op, obs_din} !== {1'b0, SH, 32'hAAAA1234}) begin
            n_bad++; $display("FAIL sh_bus got rw=%b op=%b d=%h want 0/101001/aaaa1234", obs_rw, obs_op, obs_din); end
        n_cmp++; if (obs_rdata !== 32'h00000080) begin n_bad++; $display("FAIL sh_rdata got %h want 00000080", obs_rdata); end
        ref_predict(LHU, 32'h20, 32'h0, 2);
        run_access(LHU, 32'h20, 32'h0, 2, 0, 0);
        n_cmp++; if (obs_rdata !== 32'h00001234) begin n_bad++; $display("FAIL lhu_rdata got %h want 00001234", obs_rdata); end
    endtask

    task automatic test_validation();
        logic [5:0]  ops [7] = '{LW, LW, 6'b001000, LH, SB, LW, LHU};
        logic [31:0] ads [7] = '{32'h2, 32'h1FE, 32'h40, 32'h1FE, 32'h1FF, 32'h1FC, 32'h201};
        int          knd [7] = '{2, 2, 2, 1, 1, 1, 2};
        for (int i = 0; i < 7; i++) begin
            ref_predict(ops[i], ads[i], 32'h5A5A5A5A, 0);
            run_access(ops[i], ads[i], 32'h5A5A5A5A, 0, 0, 0);
            n_cmp++; if (obs_kind !== knd[i] || obs_cyc !== exp_cyc) begin
                n_bad++; $display("FAIL val%0d outcome got kind=%0d cyc=%0d want %0d/%0d", i, obs_kind, obs_cyc, knd[i], exp_cyc); end
            n_cmp++; if (obs_mov !== exp_mov || obs_ready_after !== 1'b1) begin
                n_bad++; $display("FAIL val%0d mov got mov=%0d rdy=%b want %0d/1", i, obs_mov, obs_ready_after, exp_mov); end
            if (knd[i] == 2) begin
                n_cmp++; if (obs_ready_res !== 1'b1 || {obs_op, obs_addr} !== {m_op, m_addr}) begin
                    n_bad++; $display("FAIL val%0d idle got rdy=%b op=%b a=%h want 1/%b/%h", i, obs_ready_res, obs_op, obs_addr, m_op, m_addr); end
            end
        end
    endtask

    task automatic test_timeout();
        ref_predict(LW, 32'h14, 32'h0, TIMEOUT);
        run_access(LW, 32'h14, 32'h0, TIMEOUT, 0, 0);
        n_cmp++; if (obs_kind !== 2 || obs_cyc !== TIMEOUT + 3) begin n_bad++; $display("FAIL to_err got kind=%0d cyc=%0d want 2/%0d", obs_kind, obs_cyc, TIMEOUT + 3); end
        n_cmp++; if (obs_mov !== TIMEOUT + 1 || obs_mov_after !== 1'b0 || obs_ready_after !== 1'b1) begin
            n_bad++; $display("FAIL to_mov got mov=%0d after=%b rdy=%b want %0d/0/1", obs_mov, obs_mov_after, obs_ready_after, TIMEOUT + 1); end
        n_cmp++; if (obs_rdata !== m_rdata) begin n_bad++; $display("FAIL to_rdata got %h want %h", obs_rdata, m_rdata); end
        ref_predict(LW, 32'h10, 32'h0, TIMEOUT - 1);
        run_access(LW, 32'h10, 32'h0, TIMEOUT - 1, 0, 0);
        n_cmp++; if (obs_kind !== 1 || obs_cyc !== TIMEOUT + 3 || obs_rdata !== 32'h12345678) begin
            n_bad++; $display("FAIL to_edge got kind=%0d cyc=%0d rd=%h want 1/%0d/12345678", obs_kind, obs_cyc, obs_rdata, TIMEOUT + 3); end
        ref_predict(LW, 32'h14, 32'h0, 0);
        run_access(LW, 32'h14, 32'h0, 0, 0, 0);
        n_cmp++; if (obs_kind !== 1 || obs_rdata !== m_rdata) begin n_bad++; $display("FAIL to_after got kind=%0d rd=%h want 1/%h", obs_kind, obs_rdata, m_rdata); end
    endtask

    task automatic test_reset_mid();
        bit pulse;
        @(negedge clk);
        moc_delay = 10; ram_stale = 0;
        req = 1'b1; op_in = LW; addr_in = 32'h10;
        @(posedge clk);
        #1 req = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++; if (MOV !== 1'b1) begin n_bad++; $display("FAIL rmid_pre got MOV=%b want 1", MOV); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++; if ({ready, done, error, MOV} !== 4'b1000 || rdata !== 32'd0) begin
            n_bad++; $display("FAIL rmid_ctrl got r/d/e/m=%b rd=%h want 1000/0", {ready, done, error, MOV}, rdata); end
        n_cmp++; if ({ReadWrite, OP, Address, DataIn} !== {1'b1, 6'd0, 32'd0, 32'd0}) begin
            n_bad++; $display("FAIL rmid_bus got rw=%b op=%b a=%h d=%h want 1/0/0/0", ReadWrite, OP, Address, DataIn); end
        pulse = 0;
        repeat (4) begin @(negedge clk); if (done || error || MOV) pulse = 1; end
        n_cmp++; if (pulse !== 1'b0) begin n_bad++; $display("FAIL rmid_quiet got activity=%b want 0", pulse); end
        m_rdata = 32'd0; m_op = 6'd0; m_rw = 1'b1; m_addr = 32'd0; m_din = 32'd0;
        ref_predict(LW, 32'h10, 32'h0, 2);
        run_access(LW, 32'h10, 32'h0, 2, 0, 0);
        n_cmp++; if (obs_kind !== 1 || obs_cyc !== 6 || obs_rdata !== 32'h12345678) begin
            n_bad++; $display("FAIL rmid_after got kind=%0d cyc=%0d rd=%h want 1/6/12345678", obs_kind, obs_cyc, obs_rdata); end
    endtask

    task automatic test_random();
        logic [5:0]  lops [8] = '{LW, LH, LHU, LB, LBU, SW, SH, SB};
        logic [5:0]  op;
        logic [31:0] addr, wdata;
        int d, sz, k;
        bit st, bz;
        for (int i = 0; i < 60; i++) begin
            op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : lops[$urandom_range(0, 7)];
            sz = (ref_size(op) == 0) ? 1 : ref_size(op);
            k  = $urandom_range(0, 5);
            if (k <= 2)      addr = 32'($urandom_range(0, ADDR_LIMIT - 1)) & ~32'(sz - 1);
            else if (k == 3) addr = 32'(ADDR_LIMIT - 4 + $urandom_range(0, 7));
            else if (k == 4) addr = 32'($urandom_range(0, 600));
            else             addr = $urandom;
            d  = ($urandom_range(0, 4) == 0) ? $urandom_range(TIMEOUT - 3, TIMEOUT + 2) : $urandom_range(0, 3);
            st = 1'($urandom_range(0, 1));
            bz = 1'($urandom_range(0, 1));
            wdata = $urandom;
            ref_predict(op, addr, wdata, d);
            run_access(op, addr, wdata, d, st, bz);
            n_cmp++; if (obs_kind !== exp_kind || obs_cyc !== exp_cyc) begin
                n_bad++; $display("FAIL rnd%0d outcome op=%b a=%h d=%0d got kind=%0d cyc=%0d want %0d/%0d", i, op, addr, d, obs_kind, obs_cyc, exp_kind, exp_cyc); end
            n_cmp++; if (obs_mov !== exp_mov || obs_both !== 1'b0 || obs_extra !== 1'b0) begin
                n_bad++; $display("FAIL rnd%0d mov got mov=%0d both=%b extra=%b want %0d/0/0", i, obs_mov, obs_both, obs_extra, exp_mov); end
            n_cmp++; if (obs_rdata !== m_rdata) begin n_bad++; $display("FAIL rnd%0d rdata got %h want %h", i, obs_rdata, m_rdata); end
            n_cmp++; if ({obs_op, obs_rw, obs_addr, obs_din} !== {m_op, m_rw, m_addr, m_din}) begin
                n_bad++; $display("FAIL rnd%0d bus got op=%b rw=%b a=%h d=%h want %b/%b/%h/%h", i, obs_op, obs_rw, obs_addr, obs_din, m_op, m_rw, m_addr, m_din); end
            n_cmp++; if (obs_ready0 !== 1'b1 || obs_ready_after !== 1'b1 || obs_mov_after !== 1'b0) begin
                n_bad++; $display("FAIL rnd%0d idle got r0=%b rdy=%b mov=%b want 1/1/0", i, obs_ready0, obs_ready_after, obs_mov_after); end
        end
    endtask

    initial begin
        for (int i = 0; i < ADDR_LIMIT; i++) ram_mem[i] = 8'($urandom);
        ram_mem[16] = 8'h12; ram_mem[17] = 8'h34; ram_mem[18] = 8'h56; ram_mem[19] = 8'h78;
        ram_mem[5] = 8'h80;
        for (int i = 0; i < ADDR_LIMIT; i++) ref_mem[i] = ram_mem[i];
        test_reset();
        test_lw_basic();
        test_sign_ext();
        test_store();
        test_validation();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired before the test sequence finished");
        $fatal(1, "watchdog");
    end

endmodule
